// File: rtl/simon_pipelined_stream_sched.sv
// Streaming scheduler for a pipelined SIMON32/64 core.
// Issues one plaintext read per cycle, tracks each block through the core
// with a valid/index shift pipeline, and writes every ciphertext back to the
// same word index it was read from.

// One stage of the in-flight tracking pipeline: a valid bit plus the block
// index that travels alongside it.
module simon_sched_stage #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_in,
  input  logic [CNT_W-1:0] idx_in,
  output logic             vld_out,
  output logic [CNT_W-1:0] idx_out
);

  // Shift one step per clock; reset flushes the valid bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_out <= 1'b0;
      idx_out <= '0;
    end else begin
      vld_out <= vld_in;
      idx_out <= idx_in;
    end
  end

endmodule

module simon_pipelined_stream_sched #(
  parameter int CORE_LATENCY = 3,
  parameter int CNT_W        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_in_begin,
  input  logic [CNT_W-1:0] ctrl_in_num_blocks,
  input  logic [63:0]      ctrl_in_key,
  output logic             busy,
  output logic             done_intr,
  output logic [31:0]      pt_addra,
  input  logic [31:0]      pt_rd_data,
  output logic [31:0]      ct_addra,
  output logic [31:0]      ct_wr_data,
  output logic [3:0]       ct_wea,
  output logic             core_load,
  output logic [31:0]      core_plaintext,
  output logic [63:0]      core_key,
  input  logic [31:0]      core_ciphertext
);

  // Stage 0 lines up with the BRAM read data (1-cycle read latency); the
  // last stage lines up with the core output CORE_LATENCY cycles later.
  localparam int STAGES = CORE_LATENCY;
  localparam logic [CNT_W-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                       state, state_nx;
  logic   [CNT_W-1:0]           rd_idx;
  logic   [CNT_W-1:0]           num_blk;
  logic   [63:0]                key_q;
  logic                         issue;
  logic   [STAGES:0]            vld_pipe;
  logic   [STAGES:0][CNT_W-1:0] idx_pipe;

  // State register plus job setup (latch count/key, clear index) and
  // index advance while issuing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      rd_idx  <= '0;
      num_blk <= '0;
      key_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && ctrl_in_begin) begin
        num_blk <= ctrl_in_num_blocks;
        key_q   <= ctrl_in_key;
        rd_idx  <= '0;
      end else if (issue) begin
        rd_idx <= rd_idx + ONE;
      end
    end
  end

  // Next-state logic. DRAIN looks at every stage but the last: once those
  // are empty, the only block left is being written this cycle, so DONE
  // lands on the cycle right after the final write.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_in_begin)
          state_nx = (ctrl_in_num_blocks == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (rd_idx == num_blk - ONE)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (vld_pipe[STAGES-1:0] == '0)
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Tracking pipeline: stage 0 is fed by the issue slot, each later stage
  // by its predecessor.
  for (genvar s = 0; s <= STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      simon_sched_stage #(.CNT_W(CNT_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (issue),
        .idx_in  (rd_idx),
        .vld_out (vld_pipe[s]),
        .idx_out (idx_pipe[s])
      );
    end else begin : g_body
      simon_sched_stage #(.CNT_W(CNT_W)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (vld_pipe[s-1]),
        .idx_in  (idx_pipe[s-1]),
        .vld_out (vld_pipe[s]),
        .idx_out (idx_pipe[s])
      );
    end
  end

  assign busy           = (state != S_IDLE);
  assign done_intr      = (state == S_DONE);
  assign pt_addra       = 32'({rd_idx, 2'b00});
  assign core_load      = vld_pipe[0];
  assign core_plaintext = pt_rd_data;
  assign core_key       = key_q;

  // Ciphertext write port: active only when the last stage holds a block.
  always_comb begin
    ct_wea     = 4'h0;
    ct_addra   = 32'h0;
    ct_wr_data = 32'h0;
    if (vld_pipe[STAGES]) begin
      ct_wea     = 4'hF;
      ct_addra   = 32'({idx_pipe[STAGES], 2'b00});
      ct_wr_data = core_ciphertext;
    end
  end

endmodule

// File: tb/tb_simon_pipelined_stream_sched.sv
// Bench for simon_pipelined_stream_sched: three instances (core latency 3, 1
// and 10) share the control inputs, each with its own plaintext BRAM read
// port and a behavioural SIMON32/64 core of matching latency.
`timescale 1ns/1ps
module tb_simon_pipelined_stream_sched;
  localparam int CNT_W = 11;
  localparam int NI    = 3;
  localparam int LOGSZ = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic             ctrl_in_begin = 1'b0;
  logic [CNT_W-1:0] ctrl_in_num_blocks = '0;
  logic [63:0]      ctrl_in_key = '0;

  logic [NI-1:0]        busy, done_intr, core_load;
  logic [NI-1:0][31:0]  pt_addra, ct_addra, ct_wr_data, core_plaintext;
  logic [NI-1:0][3:0]   ct_wea;
  logic [NI-1:0][63:0]  core_key;

  logic [31:0] pt_mem [2048];
  int cyc = 0;
  int nvec = 0, nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(int g);
    return (g == 0) ? 3 : ((g == 1) ? 1 : 10);
  endfunction

  function automatic logic [15:0] rol16(logic [15:0] v, int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // Reference SIMON32/64 encryption (32 rounds, z0 sequence).
  function automatic logic [31:0] simon_enc(logic [31:0] pt, logic [63:0] key);
    logic [61:0] z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rol16(k[i-1], 13) ^ k[i-3];
      t = t ^ rol16(t, 15);
      k[i] = ~k[i-4] ^ t ^ 16'(z[61-(i-4)]) ^ 16'h0003;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 3 : ((g == 1) ? 1 : 10);
    logic [31:0] prd;
    logic [31:0] cpipe [L];

    always @(posedge clk) prd <= pt_mem[pt_addra[g][12:2]];

    always @(posedge clk) begin
      cpipe[0] <= core_load[g] ? simon_enc(core_plaintext[g], core_key[g]) : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
    end

    simon_pipelined_stream_sched #(.CORE_LATENCY(L), .CNT_W(CNT_W)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .ctrl_in_begin      (ctrl_in_begin),
      .ctrl_in_num_blocks (ctrl_in_num_blocks),
      .ctrl_in_key        (ctrl_in_key),
      .busy               (busy[g]),
      .done_intr          (done_intr[g]),
      .pt_addra           (pt_addra[g]),
      .pt_rd_data         (prd),
      .ct_addra           (ct_addra[g]),
      .ct_wr_data         (ct_wr_data[g]),
      .ct_wea             (ct_wea[g]),
      .core_load          (core_load[g]),
      .core_plaintext     (core_plaintext[g]),
      .core_key           (core_key[g]),
      .core_ciphertext    (cpipe[L-1])
    );
  end

  // Event logs, sampled on the falling edge and stamped with the cycle number.
  int          ld_n [NI] = '{default: 0};
  int          ld_cyc [NI][LOGSZ];
  int          wr_n [NI] = '{default: 0};
  int          wr_cyc [NI][LOGSZ];
  logic [31:0] wr_addr [NI][LOGSZ];
  logic [31:0] wr_dat [NI][LOGSZ];
  logic [3:0]  wr_we [NI][LOGSZ];
  int          dn_n [NI] = '{default: 0};
  int          dn_cyc [NI][64];
  int          bz_n [NI] = '{default: 0};
  int          rise_n [NI] = '{default: 0};
  int          rise_cyc [NI][64];
  logic [NI-1:0] busy_q = '0;

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (core_load[g] === 1'b1) begin
        ld_cyc[g][ld_n[g] % LOGSZ] <= cyc;
        ld_n[g] <= ld_n[g] + 1;
      end
      if (ct_wea[g] != 4'h0) begin
        wr_cyc[g][wr_n[g] % LOGSZ]  <= cyc;
        wr_addr[g][wr_n[g] % LOGSZ] <= ct_addra[g];
        wr_dat[g][wr_n[g] % LOGSZ]  <= ct_wr_data[g];
        wr_we[g][wr_n[g] % LOGSZ]   <= ct_wea[g];
        wr_n[g] <= wr_n[g] + 1;
      end
      if (done_intr[g] === 1'b1) begin
        dn_cyc[g][dn_n[g] % 64] <= cyc;
        dn_n[g] <= dn_n[g] + 1;
      end
      if (busy[g] === 1'b1) begin
        bz_n[g] <= bz_n[g] + 1;
        if (!busy_q[g]) begin
          rise_cyc[g][rise_n[g] % 64] <= cyc;
          rise_n[g] <= rise_n[g] + 1;
        end
      end
      busy_q[g] <= (busy[g] === 1'b1);
    end
  end

  // Snapshots of the log counters taken at the start of each job.
  int ld_base [NI], wr_base [NI], dn_base [NI], bz_base [NI], rise_base [NI];

  // Model: count logged writes that differ from the expected stream of n
  // ciphertexts at consecutive cycles starting at c0.
  function automatic int write_diffs(int g, int wbase, int n, int c0, logic [63:0] key);
    int d = 0;
    for (int j = 0; j < n; j++) begin
      int k = (wbase + j) % LOGSZ;
      if (wr_cyc[g][k] != c0 + j || wr_addr[g][k] != 32'(j * 4) ||
          wr_we[g][k] != 4'hF || wr_dat[g][k] != simon_enc(pt_mem[j], key))
        d++;
    end
    return d;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drive a begin; returns one cycle later with t0 = the cycle begin was sampled.
  task automatic launch(input int n, input logic [63:0] key, input bit hold, output int t0);
    step();
    for (int g = 0; g < NI; g++) begin
      ld_base[g] = ld_n[g]; wr_base[g] = wr_n[g]; dn_base[g] = dn_n[g];
      bz_base[g] = bz_n[g]; rise_base[g] = rise_n[g];
    end
    ctrl_in_num_blocks = CNT_W'(n);
    ctrl_in_key        = key;
    ctrl_in_begin      = 1'b1;
    t0 = cyc;
    step();
    if (!hold) ctrl_in_begin = 1'b0;
  endtask

  task automatic wait_jobs(input int jobs, input int budget);
    int n = 0;
    bit all;
    do begin
      step();
      n++;
      all = 1'b1;
      for (int g = 0; g < NI; g++) if (dn_n[g] - dn_base[g] < jobs) all = 1'b0;
    end while (!all && n < budget);
    nvec++;
    if (!all) begin
      nerr++;
      $display("FAIL timeout: done_intr count below %0d after %0d cycles", jobs, budget);
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ctrl_in_begin = 1'b1;
    repeat (3) step();
    for (int g = 0; g < NI; g++) begin
      nvec++;
      if ({busy[g], done_intr[g], core_load[g], ct_wea[g]} !== 7'h0) begin
        nerr++;
        $display("FAIL reset_ctrl inst%0d: got busy=%b done=%b load=%b wea=%h, want all 0",
                 g, busy[g], done_intr[g], core_load[g], ct_wea[g]);
      end
      nvec++;
      if ({pt_addra[g], ct_addra[g], ct_wr_data[g]} !== 96'h0) begin
        nerr++;
        $display("FAIL reset_bus inst%0d: got pt_addra=%h ct_addra=%h ct_wr_data=%h, want 0",
                 g, pt_addra[g], ct_addra[g], ct_wr_data[g]);
      end
      nvec++;
      if (core_key[g] !== 64'h0) begin
        nerr++;
        $display("FAIL reset_key inst%0d: got %h want 0", g, core_key[g]);
      end
    end
    ctrl_in_begin = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int t0, L;
    pt_mem[0] = 32'h65656877;
    launch(1, 64'h1918111009080100, 1'b0, t0);
    wait_jobs(1, 40);
    for (int g = 0; g < NI; g++) begin
      L = lat(g);
      nvec++;
      if (ld_n[g] - ld_base[g] !== 1 || ld_cyc[g][ld_base[g] % LOGSZ] !== t0 + 2) begin
        nerr++;
        $display("FAIL single_load inst%0d: got %0d loads first at rel %0d, want 1 at rel 2",
                 g, ld_n[g] - ld_base[g], ld_cyc[g][ld_base[g] % LOGSZ] - t0);
      end
      nvec++;
      if (wr_n[g] - wr_base[g] !== 1 || wr_dat[g][wr_base[g] % LOGSZ] !== 32'hc69be9bb ||
          wr_addr[g][wr_base[g] % LOGSZ] !== 32'h0 || wr_cyc[g][wr_base[g] % LOGSZ] !== t0 + 2 + L) begin
        nerr++;
        $display("FAIL single_write inst%0d: got %0d writes data=%h addr=%h rel %0d, want 1 c69be9bb @0 rel %0d",
                 g, wr_n[g] - wr_base[g], wr_dat[g][wr_base[g] % LOGSZ],
                 wr_addr[g][wr_base[g] % LOGSZ], wr_cyc[g][wr_base[g] % LOGSZ] - t0, 2 + L);
      end
      nvec++;
      if (dn_n[g] - dn_base[g] !== 1 || dn_cyc[g][dn_base[g] % 64] !== t0 + 3 + L) begin
        nerr++;
        $display("FAIL single_done inst%0d: got %0d pulses at rel %0d, want 1 at rel %0d",
                 g, dn_n[g] - dn_base[g], dn_cyc[g][dn_base[g] % 64] - t0, 3 + L);
      end
      nvec++;
      if (bz_n[g] - bz_base[g] !== 3 + L || rise_cyc[g][rise_base[g] % 64] !== t0 + 1) begin
        nerr++;
        $display("FAIL single_busy inst%0d: got %0d cycles from rel %0d, want %0d from rel 1",
                 g, bz_n[g] - bz_base[g], rise_cyc[g][rise_base[g] % 64] - t0, 3 + L);
      end
    end
  endtask

  task automatic test_stream(input int n);
    int t0, L, d;
    logic [63:0] key;
    key = {$urandom, $urandom};
    for (int i = 0; i < n; i++) pt_mem[i] = $urandom;
    launch(n, key, 1'b0, t0);
    wait_jobs(1, n + 60);
    for (int g = 0; g < NI; g++) begin
      L = lat(g);
      nvec++;
      if (ld_n[g] - ld_base[g] !== n || ld_cyc[g][ld_base[g] % LOGSZ] !== t0 + 2 ||
          ld_cyc[g][(ld_base[g] + n - 1) % LOGSZ] !== t0 + n + 1) begin
        nerr++;
        $display("FAIL stream%0d_load inst%0d: got %0d loads rel %0d..%0d, want %0d rel 2..%0d",
                 n, g, ld_n[g] - ld_base[g], ld_cyc[g][ld_base[g] % LOGSZ] - t0,
                 ld_cyc[g][(ld_base[g] + n - 1) % LOGSZ] - t0, n, n + 1);
      end
      nvec++;
      if (wr_n[g] - wr_base[g] !== n) begin
        nerr++;
        $display("FAIL stream%0d_wcount inst%0d: got %0d writes, want %0d", n, g, wr_n[g] - wr_base[g], n);
      end
      d = write_diffs(g, wr_base[g], n, t0 + 2 + L, key);
      nvec++;
      if (d !== 0) begin
        nerr++;
        $display("FAIL stream%0d_writes inst%0d: got %0d writes differing from model, want 0", n, g, d);
      end
      nvec++;
      if (dn_n[g] - dn_base[g] !== 1 || dn_cyc[g][dn_base[g] % 64] !== t0 + n + 2 + L) begin
        nerr++;
        $display("FAIL stream%0d_done inst%0d: got %0d pulses at rel %0d, want 1 at rel %0d",
                 n, g, dn_n[g] - dn_base[g], dn_cyc[g][dn_base[g] % 64] - t0, n + 2 + L);
      end
      nvec++;
      if (bz_n[g] - bz_base[g] !== n + 2 + L) begin
        nerr++;
        $display("FAIL stream%0d_busy inst%0d: got %0d busy cycles, want %0d", n, g, bz_n[g] - bz_base[g], n + 2 + L);
      end
    end
  endtask

  task automatic test_zero();
    int t0;
    launch(0, {$urandom, $urandom}, 1'b0, t0);
    wait_jobs(1, 20);
    for (int g = 0; g < NI; g++) begin
      nvec++;
      if (dn_n[g] - dn_base[g] !== 1 || dn_cyc[g][dn_base[g] % 64] !== t0 + 1) begin
        nerr++;
        $display("FAIL zero_done inst%0d: got %0d pulses at rel %0d, want 1 at rel 1",
                 g, dn_n[g] - dn_base[g], dn_cyc[g][dn_base[g] % 64] - t0);
      end
      nvec++;
      if (ld_n[g] - ld_base[g] !== 0 || wr_n[g] - wr_base[g] !== 0) begin
        nerr++;
        $display("FAIL zero_activity inst%0d: got %0d loads %0d writes, want 0 and 0",
                 g, ld_n[g] - ld_base[g], wr_n[g] - wr_base[g]);
      end
      nvec++;
      if (bz_n[g] - bz_base[g] !== 1) begin
        nerr++;
        $display("FAIL zero_busy inst%0d: got %0d busy cycles, want 1", g, bz_n[g] - bz_base[g]);
      end
    end
  endtask

  task automatic test_hold_begin();
    int t0, L, d, n;
    logic [63:0] key1, key2;
    key1 = {$urandom, $urandom};
    key2 = ~key1 ^ {$urandom, $urandom};
    for (int i = 0; i < 4; i++) pt_mem[i] = $urandom;
    launch(4, key1, 1'b1, t0);
    step();
    ctrl_in_key = key2;
    wait_jobs(2, 80);
    ctrl_in_begin = 1'b0;
    n = 0;
    while (busy !== '0 && n < 100) begin step(); n++; end
    nvec++;
    if (busy !== '0) begin
      nerr++;
      $display("FAIL hold_idle: got busy=%b after releasing begin, want 000", busy);
    end
    for (int g = 0; g < NI; g++) begin
      L = lat(g);
      d = write_diffs(g, wr_base[g], 4, t0 + 2 + L, key1);
      nvec++;
      if (d !== 0) begin
        nerr++;
        $display("FAIL hold_job1 inst%0d: got %0d writes differing from original-key model, want 0", g, d);
      end
      d = write_diffs(g, wr_base[g] + 4, 4, t0 + (4 + 3 + L) + 2 + L, key2);
      nvec++;
      if (d !== 0) begin
        nerr++;
        $display("FAIL hold_job2 inst%0d: got %0d writes differing from restarted-job model, want 0", g, d);
      end
      nvec++;
      if (rise_cyc[g][rise_base[g] % 64] !== t0 + 1 ||
          rise_cyc[g][(rise_base[g] + 1) % 64] !== t0 + 4 + 4 + L) begin
        nerr++;
        $display("FAIL hold_restart inst%0d: got busy rises at rel %0d,%0d, want 1,%0d", g,
                 rise_cyc[g][rise_base[g] % 64] - t0, rise_cyc[g][(rise_base[g] + 1) % 64] - t0, 8 + L);
      end
      nvec++;
      if (dn_cyc[g][dn_base[g] % 64] !== t0 + 4 + 2 + L) begin
        nerr++;
        $display("FAIL hold_done inst%0d: got first done at rel %0d, want %0d",
                 g, dn_cyc[g][dn_base[g] % 64] - t0, 6 + L);
      end
    end
  endtask

  task automatic test_reset_midjob();
    int t0, bad;
    launch(16, {$urandom, $urandom}, 1'b0, t0);
    while (cyc < t0 + 4) step();
    rst = 1'b0;
    step();
    for (int g = 0; g < NI; g++) begin
      nvec++;
      if ({busy[g], done_intr[g], core_load[g], ct_wea[g], pt_addra[g], ct_addra[g],
           ct_wr_data[g], core_key[g]} !== '0) begin
        nerr++;
        $display("FAIL midrst_outputs inst%0d: got busy=%b done=%b load=%b wea=%h pt=%h ct=%h wd=%h key=%h, want all 0",
                 g, busy[g], done_intr[g], core_load[g], ct_wea[g], pt_addra[g], ct_addra[g],
                 ct_wr_data[g], core_key[g]);
      end
    end
    rst = 1'b1;
    repeat (40) step();
    for (int g = 0; g < NI; g++) begin
      bad = 0;
      for (int j = wr_base[g]; j < wr_n[g]; j++) if (wr_cyc[g][j % LOGSZ] >= t0 + 5) bad++;
      nvec++;
      if (bad !== 0 || dn_n[g] - dn_base[g] !== 0) begin
        nerr++;
        $display("FAIL midrst_quiet inst%0d: got %0d writes and %0d done pulses after reset, want 0 and 0",
                 g, bad, dn_n[g] - dn_base[g]);
      end
    end
    test_stream(2);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) pt_mem[i] = '0;
    test_reset();
    test_single();
    test_stream(8);
    test_zero();
    test_hold_begin();
    test_reset_midjob();
    test_stream(2047);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/simon_pipelined_stream_sched.md
# simon_pipelined_stream_sched

Streaming scheduler for the pipelined SIMON32/64 cipher core. It issues one plaintext block per clock from the plaintext BRAM into the core, and tracks every block in flight with a valid/index shift pipeline. Each ciphertext is written to the ciphertext BRAM at the same word index as its plaintext. It sits between the AXI slave-register block (begin, block count, key, interrupt) and the two BRAM ports, and replaces the one-block-at-a-time sequencing with full pipeline throughput.

## Interface
Parameters:
- CORE_LATENCY, 3, cycles from core_load high to matching core_ciphertext valid; legal range 1–64
- CNT_W, 11, width of block count and block index

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- ctrl_in_begin  in  1  start request; level or pulse, sampled in IDLE only
- ctrl_in_num_blocks  in  CNT_W  number of blocks to encrypt; latched at start
- ctrl_in_key  in  64  cipher key; latched at start
- busy  out  1  high from the cycle after start through the DONE cycle
- done_intr  out  1  one-cycle completion pulse
- pt_addra  out  32  plaintext BRAM byte address, equal to {index, 2'b00}
- pt_rd_data  in  32  plaintext BRAM read data; 1-cycle read latency
- ct_addra  out  32  ciphertext BRAM byte address
- ct_wr_data  out  32  ciphertext write data
- ct_wea  out  4  ciphertext byte write enables
- core_load  out  1  accepts core_plaintext into the pipeline this cycle
- core_plaintext  out  32  driven directly by pt_rd_data
- core_key  out  64  latched key, held constant for the whole job
- core_ciphertext  in  32  core output, valid CORE_LATENCY cycles after its load

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - If ctrl_in_begin=1: latch N=ctrl_in_num_blocks and the key, and clear the issue index rd_idx.
  - If N≠0, go to ISSUE; if N=0, go directly to DONE.
- ISSUE
  - Each cycle: pt_addra={rd_idx,2'b00}, push valid=1 and rd_idx into stage 0 of the tracking pipeline, then rd_idx++.
  - When rd_idx=N-1 is issued, go to DRAIN.
- Tracking pipeline: depth 1+CORE_LATENCY, holding a valid bit and a CNT_W-bit index per stage.
  - Stage 0 valid (one cycle after issue) drives core_load=1. core_plaintext is pt_rd_data.
  - The final stage valid drives ct_wea=4'hF, ct_addra={index,2'b00} and ct_wr_data=core_ciphertext.
- DRAIN
  - No new issues; the pipeline shifts in 0.
  - When the pipeline is empty (no valid bits), go to DONE.
- DONE
  - done_intr=1 for this single cycle, then return to IDLE.
- ctrl_in_begin is ignored in ISSUE, DRAIN and DONE. A begin still held high in IDLE after DONE restarts a new job.
- Changes to ctrl_in_num_blocks or ctrl_in_key mid-job have no effect.
- Width rule: N up to 2^CNT_W-1. Index arithmetic is CNT_W-bit; the compare uses the latched N, and no wrap occurs within a job.
- Default outputs when idle or not writing:
  - core_load=0, ct_wea=0, ct_wr_data=0
  - ct_addra=0, and pt_addra holds {rd_idx,2'b00}

## Timing
- Reset (rst=0 at a clock edge), effective next cycle:
  - Registers: state=IDLE, pipeline valids=0, rd_idx=0, latched N=0, key=0.
  - Outputs: busy=0, done_intr=0, core_load=0, ct_wea=0, pt_addra=0, ct_addra=0, ct_wr_data=0, core_key=0.
- Reset mid-job: the pipeline is flushed, no further ct writes occur, and done_intr is not pulsed.
- Job timeline, with begin sampled in IDLE at cycle 0:
  - Issues at cycles 1..N.
  - Loads at cycles 2..N+1.
  - Writes at cycles 2+CORE_LATENCY..N+1+CORE_LATENCY.
  - done_intr at cycle N+2+CORE_LATENCY.
- Throughput: one block per cycle, with no bubbles between consecutive blocks.
- N=0: done_intr at cycle 1, with no BRAM or core activity.
- busy is 1 from cycle 1 through the done_intr cycle inclusive.

## Test plan
- CORE_LATENCY=3, N=1, key 0x1918111009080100, PT[0]=0x65656877 -> one load at cycle 2; CT[0]=0xc69be9bb written at cycle 5 with ct_addra=0; done_intr at cycle 6.
- N=8 with distinct plaintexts -> core_load high for exactly 8 consecutive cycles; 8 consecutive writes to ct_addra 0x0..0x1C, each matching the reference-model ciphertext; a single done_intr pulse.
- N=0 with begin=1 -> done_intr at cycle 1; ct_wea and core_load never asserted.
- Begin held high throughout an N=4 job, and ctrl_in_key changed at cycle 2 -> begin is ignored until IDLE; all 4 ciphertexts use the original key; the job restarts after DONE.
- rst=0 at cycle 4 of an N=16 job -> state IDLE and all outputs at reset values the next cycle; no writes follow and no done_intr; a fresh N=2 job then completes correctly.
- CORE_LATENCY=1 and CORE_LATENCY=10 sweeps with N=2047 -> every write index matches its issue index; done_intr at cycle N+2+CORE_LATENCY.
